// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states and default sizes for the stack CPU
package cpu_pkg;

    localparam int CPU_DATA_RANGE = 8;
    localparam int CPU_DEPTH      = 16;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_POP  = 3'b010,
        OP_DUP  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_AND  = 3'b110,
        OP_OR   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // The four two-operand ops share the top opcode bit.
    function automatic logic is_binary(input op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - stack storage: one synchronous write port, one asynchronous read port
module stack_ram #(
    parameter int DATA_RANGE = 8,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [$clog2(DEPTH)-1:0]     waddr_i,
    input  logic [DATA_RANGE-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0]     raddr_i,
    output logic [DATA_RANGE-1:0]        rdata_o
);

    logic [DATA_RANGE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - LIFO stack with a five-state command FSM and a small ALU
module stack_unit
    import cpu_pkg::*;
#(
    parameter int DATA_RANGE = CPU_DATA_RANGE,
    parameter int DEPTH      = CPU_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [DATA_RANGE-1:0]   cmd_data,
    output logic                    rsp_valid,
    output logic [DATA_RANGE-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   SP_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   SP_TWO   = (AW+1)'(2);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_e                state_q;
    op_e                   op_q;
    logic [DATA_RANGE-1:0] data_q;
    logic [DATA_RANGE-1:0] a_q;
    logic [DATA_RANGE-1:0] b_q;
    logic [AW:0]           sp_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_RANGE-1:0] rsp_data_q;

    op_e                   cmd_op_d;
    logic                  cmd_err_d;
    logic [DATA_RANGE-1:0] alu_d;
    logic [DATA_RANGE-1:0] wr_data_d;
    logic [DATA_RANGE-1:0] rd_data;
    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         wr_addr;
    logic                  wr_en;

    // sp_q points at the next free slot, so the top entry lives at sp_q-1.
    assign rd_addr = sp_q[AW-1:0] - ADDR_ONE;
    assign wr_addr = sp_q[AW-1:0];
    assign wr_en   = (state_q == ST_WRITE);

    stack_ram #(
        .DATA_RANGE (DATA_RANGE),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data_d),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        cmd_op_d  = op_e'(cmd_op);
        cmd_err_d = 1'b0;
        if (is_binary(cmd_op_d)) begin
            cmd_err_d = (sp_q < SP_TWO);
        end else begin
            case (cmd_op_d)
                OP_PUSH: cmd_err_d = (sp_q == SP_FULL);
                OP_POP:  cmd_err_d = (sp_q == '0);
                OP_DUP:  cmd_err_d = (sp_q == '0) || (sp_q == SP_FULL);
                default: cmd_err_d = 1'b0;
            endcase
        end
    end

    // SUB is second-from-top minus top; carries are dropped by the word width.
    always_comb begin
        alu_d = '0;
        case (op_q)
            OP_ADD:  alu_d = b_q + a_q;
            OP_SUB:  alu_d = b_q - a_q;
            OP_AND:  alu_d = b_q & a_q;
            OP_OR:   alu_d = b_q | a_q;
            default: alu_d = '0;
        endcase
    end

    always_comb begin
        wr_data_d = alu_d;
        case (op_q)
            OP_PUSH: wr_data_d = data_q;
            OP_DUP:  wr_data_d = a_q;
            default: wr_data_d = alu_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            data_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sp_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op_d;
                        data_q <= cmd_data;
                        if (cmd_err_d || cmd_op_d == OP_NOP) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= cmd_err_d;
                            rsp_data_q  <= '0;
                        end else if (cmd_op_d == OP_PUSH) begin
                            state_q <= ST_WRITE;
                        end else begin
                            state_q <= ST_READ_A;
                        end
                    end
                end
                ST_READ_A: begin
                    a_q <= rd_data;
                    if (op_q == OP_POP) begin
                        sp_q        <= sp_q - SP_ONE;
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= rd_data;
                    end else if (op_q == OP_DUP) begin
                        state_q <= ST_WRITE;
                    end else begin
                        sp_q    <= sp_q - SP_ONE;
                        state_q <= ST_READ_B;
                    end
                end
                ST_READ_B: begin
                    b_q     <= rd_data;
                    sp_q    <= sp_q - SP_ONE;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    sp_q        <= sp_q + SP_ONE;
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= wr_data_d;
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign count     = sp_q;

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - directed bench for stack_unit checked against a queue-based stack model
module tb_stack_unit;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [4:0] count;

    stack_unit #(.DATA_RANGE(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .count     (count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    logic [7:0] stk[$];
    bit         pending = 0;
    int         exp_cycle;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_count;
    logic [7:0] last_data;
    logic       last_err;
    int         last_count;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: a plain queue stack with the documented latencies.
    function automatic void model_accept(input logic [2:0] op, input logic [7:0] d);
        int n = stk.size();
        int lat = 1;
        logic [7:0] a, b, r;
        exp_data = 8'h00;
        exp_err  = 1'b0;
        case (op)
            3'b000: lat = 1;
            3'b001: if (n == 16) exp_err = 1'b1;
                    else begin stk.push_back(d); exp_data = d; lat = 2; end
            3'b010: if (n == 0) exp_err = 1'b1;
                    else begin exp_data = stk.pop_back(); lat = 2; end
            3'b011: if (n == 0 || n == 16) exp_err = 1'b1;
                    else begin exp_data = stk[n-1]; stk.push_back(stk[n-1]); lat = 3; end
            default: if (n < 2) exp_err = 1'b1;
                    else begin
                        a = stk.pop_back();
                        b = stk.pop_back();
                        case (op)
                            3'b100:  r = b + a;
                            3'b101:  r = b - a;
                            3'b110:  r = b & a;
                            default: r = b | a;
                        endcase
                        stk.push_back(r);
                        exp_data = r;
                        lat = 4;
                    end
        endcase
        exp_count = stk.size();
        exp_cycle = cyc + lat - 1;
        pending   = 1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (pending && cyc == exp_cycle) begin
                check("rsp_valid at latency", rsp_valid, 1);
                check("rsp_data", rsp_data, exp_data);
                check("rsp_err", rsp_err, exp_err);
                check("count at response", count, exp_count);
                last_data  = rsp_data;
                last_err   = rsp_err;
                last_count = count;
                pending    = 0;
            end else begin
                check("rsp_valid quiet", rsp_valid, 0);
            end
        end
    end

    task automatic wait_rsp();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (!pending) return;
        end
        check("response timeout", pending, 0);
        pending = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] d, input bit wait_done = 1'b1);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready timeout", cmd_ready, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        model_accept(op, d);
        if (wait_done) wait_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset count", count, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset cmd_ready low", cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready after reset", cmd_ready, 1);

        issue(OP_NOP, 8'h00);
        check("nop data", last_data, 8'h00);

        issue(OP_PUSH, 8'h05);
        issue(OP_PUSH, 8'h03);
        issue(OP_ADD, 8'h00);
        check("add 5+3", last_data, 8'h08);
        check("add err", last_err, 0);
        check("add count", last_count, 1);
        issue(OP_POP, 8'h00);

        issue(OP_PUSH, 8'h02);
        issue(OP_PUSH, 8'h07);
        issue(OP_SUB, 8'h00);
        check("sub 2-7", last_data, 8'hFB);
        issue(OP_POP, 8'h00);
        check("pop after sub", last_data, 8'hFB);
        check("count empty", last_count, 0);

        for (int i = 0; i < 16; i++) issue(OP_PUSH, 8'(8'h10 + i));
        issue(OP_PUSH, 8'h99);
        check("overflow err", last_err, 1);
        check("overflow count", last_count, 16);
        issue(OP_DUP, 8'h00);
        check("dup full err", last_err, 1);
        issue(OP_POP, 8'h00);
        check("pop top of full", last_data, 8'h1F);
        for (int i = 0; i < 15; i++) issue(OP_POP, 8'h00);

        issue(OP_POP, 8'h00);
        check("underflow pop", last_err, 1);
        issue(OP_DUP, 8'h00);
        check("underflow dup", last_err, 1);
        issue(OP_PUSH, 8'hAA);
        issue(OP_ADD, 8'h00);
        check("underflow add", last_err, 1);
        check("underflow add count", last_count, 1);
        issue(OP_POP, 8'h00);
        check("top still AA", last_data, 8'hAA);

        issue(OP_PUSH, 8'hFF);
        issue(OP_DUP, 8'h00);
        check("dup FF", last_data, 8'hFF);
        issue(OP_ADD, 8'h00);
        check("FF+FF", last_data, 8'hFE);
        check("count after dup add", last_count, 1);
        issue(OP_PUSH, 8'h3C);
        issue(OP_AND, 8'h00);
        issue(OP_PUSH, 8'h81);
        issue(OP_OR, 8'h00);
        check("(FE&3C)|81", last_data, 8'hBD);
        issue(OP_POP, 8'h00);

        issue(OP_PUSH, 8'h0F);
        issue(OP_PUSH, 8'hF3);
        issue(OP_AND, 8'h00, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst     = 1'b1;
        pending = 0;
        stk.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready after mid reset", cmd_ready, 1);
        check("count after mid reset", count, 0);
        repeat (4) @(negedge clk);

        issue(OP_PUSH, 8'h5A);
        issue(OP_POP, 8'h00);
        check("pop after mid reset", last_data, 8'h5A);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter DATA_RANGE, default 8, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of stack entries (power of two).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: the control unit presents a command.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the unit accepts a command this cycle.
REQ-007 SHALL have port cmd_op, input, 3 bits: operation code.
REQ-008 SHALL have port cmd_data, input, DATA_RANGE bits: PUSH operand.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rsp_data, output, DATA_RANGE bits: result value, valid with rsp_valid.
REQ-011 SHALL have port rsp_err, output, 1 bit: overflow/underflow flag, valid with rsp_valid.
REQ-012 SHALL have port count, output, log2(DEPTH)+1 bits: current number of entries.

Function
REQ-013 Op encoding SHALL be: 000 NOP, 001 PUSH, 010 POP, 011 DUP, 100 ADD, 101 SUB, 110 AND, 111 OR.
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_op and cmd_data are captured then.
REQ-015 cmd_ready SHALL be 1 only in IDLE and not during rst; one command in flight at most.
REQ-016 FSM states SHALL be IDLE, READ_A, READ_B, WRITE, RESP.
REQ-017 Transitions: NOP→RESP; PUSH→WRITE→RESP; POP→READ_A→RESP; DUP→READ_A→WRITE→RESP; ADD/SUB/AND/OR→READ_A→READ_B→WRITE→RESP; RESP→IDLE.
REQ-018 READ_A SHALL latch A=top entry, decrementing the stack pointer for POP and binary ops but not for DUP.
REQ-019 READ_B SHALL latch B=new top entry and decrement the stack pointer.
REQ-020 WRITE SHALL store cmd_data (PUSH), A (DUP), or B op A (binary) at the stack pointer and increment it.
REQ-021 SUB SHALL compute B−A (second-from-top minus top); all arithmetic SHALL be modulo 2^DATA_RANGE with carry discarded.
REQ-022 rsp_valid SHALL be 1 exactly in RESP, with latency from the accept edge of: NOP 1, PUSH 2, POP 2, DUP 3, binary 4 cycles.
REQ-023 rsp_data SHALL be the pushed value (PUSH), the popped value (POP), the duplicated value (DUP), the result (binary), or 0 (NOP/error).
REQ-024 Overflow (PUSH/DUP with count==DEPTH) and underflow (POP/DUP with count==0, binary with count<2) SHALL go IDLE→RESP with rsp_err=1 and the stack unchanged.
REQ-025 rsp_err SHALL be 0 on every non-error response.
REQ-026 count SHALL track the stack pointer and never exceed DEPTH or go below 0.

Reset
REQ-027 While rst is high at a rising edge: state←IDLE, stack pointer←0, rsp_valid←0, rsp_err←0, rsp_data←0, A/B←0.
REQ-028 Reset mid-operation SHALL abort the command with no response; storage contents are not cleared and are unobservable after reset.

Structure
REQ-029 Op encodings, FSM state encoding, and DATA_RANGE/DEPTH defaults SHALL live in the shared package cpu_pkg, shared with the control unit.
REQ-030 Storage SHALL be a sub-module stack_ram: DEPTH×DATA_RANGE, single write port (synchronous), one asynchronous read port, no reset.

Verification
REQ-031 PUSH 0x05, PUSH 0x03, ADD → rsp_valid 4 cycles after the ADD is accepted, rsp_data=0x08, rsp_err=0, count=1.
REQ-032 PUSH 0x02, PUSH 0x07, SUB → rsp_data=0xFB; then POP → rsp_data=0xFB, count=0.
REQ-033 16 PUSHes of 0x10..0x1F, then a 17th PUSH → rsp_err=1 after 1 cycle, count stays 16; POP → 0x1F.
REQ-034 Empty stack: POP → rsp_err=1; DUP → rsp_err=1; PUSH 0xAA then ADD → rsp_err=1, count=1, top still 0xAA.
REQ-035 PUSH 0xFF, DUP, ADD → DUP rsp_data=0xFF, ADD rsp_data=0xFE, count=1.
REQ-036 Assert rst during READ_B of an AND → no rsp_valid, count=0, cmd_ready=1 the cycle after rst falls.
